// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla datapath: instruction layout,
// opcode encodings and the fetch-stage state encoding.
package jericalla_pkg;

    localparam int INSTR_W = 17;

    // Instruction field positions: op | rd | rs1 | rs2
    localparam int OP_MSB  = 16;
    localparam int OP_LSB  = 15;
    localparam int RD_MSB  = 14;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 0;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_TERN = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run control, instruction-memory read port and the
// decoded-field handshake toward the control decoder / register file.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [16:0]       imem_rdata;
    logic              imem_valid;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    // Fetch unit side
    modport master (
        input  start, imem_rdata, imem_valid, out_ready,
        output imem_req, imem_addr, out_valid, op, rd, rs1, rs2, pc, busy, done
    );

    // Environment side: memory, run control and downstream consumer
    modport slave (
        output start, imem_rdata, imem_valid, out_ready,
        input  imem_req, imem_addr, out_valid, op, rd, rs1, rs2, pc, busy, done
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, instruction register and the
// request/wait/hold sequencer. Every output is decoded from state or read
// straight from a register, so out_ready and imem_valid never reach an
// output combinationally.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   REQ   | one-cycle read request at pc
//   WAIT  | waiting for imem_valid (no timeout)
//   HOLD  | fields valid, waiting for out_ready
//   DONE  | last instruction consumed, waiting for start
module instr_fetch
    import jericalla_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 2**ADDR_W - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

    fetch_state_e         r_state;
    fetch_state_e         w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0]   r_ir;
    logic                 w_ir_load;

    // State, pc and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_load) begin
                r_ir <= bus.imem_rdata;
            end
        end
    end

    // Next-state, pc update and IR load enable
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_valid) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    if (r_pc == LAST_PC) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_pc_nxt    = r_pc + ADDR_W'(1);
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = (r_state == ST_REQ);
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.busy      = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_HOLD);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.pc        = r_pc;

    // Fields come straight from IR so they stay stable through HOLD
    assign bus.op  = r_ir[OP_MSB:OP_LSB];
    assign bus.rd  = r_ir[RD_MSB:RD_LSB];
    assign bus.rs1 = r_ir[RS1_MSB:RS1_LSB];
    assign bus.rs2 = r_ir[RS2_MSB:RS2_LSB];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Upstream stage of the Jericalla single-issue datapath. It holds the program counter and fetches 17-bit instructions from the instruction memory through a request/valid interface. It splits each instruction into opcode and register fields and presents them to the control decoder and register file under a valid/ready handshake. The 2-bit `op` output drives the control decoder's opcode input directly.

## Interface
- `ADDR_W`, default 8: program counter and instruction-memory address width.
- `LAST_ADDR`, default 2**ADDR_W-1: address of the final instruction. Fetching stops after it is consumed.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begins a program run at address 0. Sampled only in IDLE and DONE.
- `imem_req`  out  1  one-cycle read request.
- `imem_addr`  out  ADDR_W  read address; equals `pc`.
- `imem_rdata`  in  17  instruction word, qualified by `imem_valid`.
- `imem_valid`  in  1  read data valid. Arrives 1 or more cycles after `imem_req`.
- `out_valid`  out  1  decoded fields are valid.
- `out_ready`  in  1  downstream accepts the fields.
- `op`  out  2  instr[16:15]; feeds the control decoder.
- `rd`  out  5  instr[14:10].
- `rs1`  out  5  instr[9:5].
- `rs2`  out  5  instr[4:0].
- `pc`  out  ADDR_W  address of the instruction held in the instruction register.
- `busy`  out  1  high in REQ, WAIT and HOLD.
- `done`  out  1  high in DONE.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, DONE.
- **IDLE**
  - `start`=1 → clear pc to 0, go to REQ.
- **REQ**
  - `imem_req`=1 for exactly this cycle, with `imem_addr`=pc.
  - Unconditionally go to WAIT.
- **WAIT**
  - `imem_valid`=1 → load `imem_rdata` into the instruction register (IR), go to HOLD.
  - Otherwise stay in WAIT. There is no timeout.
- **HOLD**
  - `out_valid`=1. `op`/`rd`/`rs1`/`rs2` are driven from IR and stay stable until accepted.
  - `out_ready`=1 and pc==LAST_ADDR → go to DONE; pc is unchanged.
  - `out_ready`=1 and pc!=LAST_ADDR → pc←pc+1, go to REQ.
  - `out_ready`=0 → stay in HOLD.
- **DONE**
  - `done`=1.
  - `start`=1 → pc←0, go to REQ, so the program restarts.
- `imem_valid` outside WAIT is ignored and does not alter IR.
- `start` in REQ, WAIT or HOLD is ignored.
- pc arithmetic is modulo 2**ADDR_W. Wrap-around never occurs because LAST_ADDR ≤ 2**ADDR_W-1 terminates the run first.
- Opcode values are passed through unchanged; 2'b11 (SW) is not treated specially here.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, pc=0, IR=0.
  - `imem_req`=0, `out_valid`=0, `busy`=0, `done`=0.
  - `op`/`rd`/`rs1`/`rs2`=0.
- Reset mid-run: abandon any outstanding read. A late `imem_valid` after reset lands in IDLE and is ignored.
- Latency:
  - `start` sampled at edge t → `imem_req` high in cycle t+1.
  - With 1-cycle memory, `out_valid` rises in cycle t+3.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD), with `out_ready` held high.
- All outputs are registered or decoded from state only. There is no combinational path from `out_ready` or `imem_valid` to any output.
- Handshake transfer happens on an edge where `out_valid`&`out_ready`=1. `out_valid` drops in the following cycle.

## Structure
- Shared package `jericalla_pkg` holds:
  - INSTR_W=17.
  - Field bit positions for op, rd, rs1 and rs2.
  - Opcode constants: OP_ADD=2'b00, OP_SUB=2'b01, OP_TERN=2'b10, OP_SW=2'b11.
  - The fetch FSM state enum.
- Single module; no sub-module needed. pc, IR and FSM together fit in one file.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → all outputs 0 immediately. Then return `imem_valid`=1 with data 17'h1_FFFF after release → IR stays 0 and state stays IDLE.
- **Single fetch:** `start` at edge 0, memory returns 17'b00_00011_00001_00010 one cycle after request → `imem_req` in cycle 1 with addr 0, `out_valid` in cycle 3, `op`=00, `rd`=3, `rs1`=1, `rs2`=2, `pc`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD → fields constant, no `imem_req`. Raise `out_ready` → next `imem_req` one cycle later with addr 1.
- **Slow memory:** delay `imem_valid` by 4 cycles → FSM stays in WAIT, no extra requests, fields captured correctly.
- **End of program:** LAST_ADDR=3, `out_ready`=1 throughout → exactly 4 transfers at pc 0..3, then `done`=1 and `busy`=0. `start` then restarts with `imem_addr`=0.
- **Opcode passthrough:** feed op 00, 01, 10, 11 in sequence → `op` outputs 0, 1, 2, 3 respectively with no dropped or duplicated transfer.
